pll_rst_seq: RTL

Reset sequencer directly downstream of the SPI-domain PLL. Runs on the PLL's 100 MHz output clock and consumes the PLL `locked` flag. It qualifies lock with a stability counter, then releases a set of staged, active-high domain resets in a fixed order, with a fixed gap between stages. Any loss of lock re-asserts every domain reset and restarts the sequence.

---
 rtl/pll_rst_pkg.sv | 20 ++
 rtl/pll_rst_seq_sync.sv | 23 ++
 rtl/pll_rst_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared types and default constants for the PLL reset sequencer.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } pll_rst_state_t;

  localparam int PLL_RST_STABLE_DEF  = 1024;
  localparam int PLL_RST_GAP_DEF     = 8;
  localparam int PLL_RST_DOMAINS_DEF = 3;

  // Larger of two ints, used to size the shared stability/stage counter.
  function automatic int pll_rst_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// sync_2ff: generic single-bit two-flop synchronizer, synchronous active-high
// reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: qualifies PLL lock with a stability counter, then releases
// staged active-high domain resets in ascending index order. Any loss of lock
// once releasing has begun re-asserts every domain and restarts the sequence.
// Optional feature macro: PLL_RST_SEQ_LOSS_CNT_EN (lock-loss event counter;
// when undefined lock_loss_count is tied to zero).
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = PLL_RST_STABLE_DEF,
  parameter int NUM_DOMAINS        = PLL_RST_DOMAINS_DEF,
  parameter int STAGE_GAP          = PLL_RST_GAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [7:0]             lock_loss_count
);

  localparam int CNT_W = $clog2(pll_rst_max(LOCK_STABLE_CYCLES, STAGE_GAP) + 1);
  localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(STAGE_GAP - 1);
  localparam logic [NUM_DOMAINS-1:0] LAST_STAGE = NUM_DOMAINS'(1) << (NUM_DOMAINS - 1);

  generate
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
      $error("pll_rst_seq: LOCK_STABLE_CYCLES must be >= 1");
    end
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
      $error("pll_rst_seq: NUM_DOMAINS must be in 1..8");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
      $error("pll_rst_seq: STAGE_GAP must be >= 1");
    end
  endgenerate

  logic             locked_s;
  pll_rst_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             stable_done;
  logic             lock_lost;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Lock has been stable long enough; a single-cycle requirement is met on
  // the very first locked edge, so WAIT_LOCK can release directly.
  assign stable_done = ((state == WAIT_LOCK) && (LOCK_STABLE_CYCLES == 1)) ||
                       ((state == STABLE) && (cnt == STABLE_TERM));

  // Only losing lock after releasing has started counts as a lock-loss event.
  assign lock_lost = ((state == RELEASE) || (state == RUN)) && !locked_s;

  // Sequencer FSM: rst_out is always a run of ones above a run of zeros, so
  // releasing the next domain is a left shift and re-assert is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK, STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (stable_done) begin
            cnt     <= '0;
            rst_out <= rst_out << 1;
            if (NUM_DOMAINS == 1) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else if (state == WAIT_LOCK) begin
            state <= STABLE;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (lock_lost) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
          end else if (cnt == GAP_TERM) begin
            cnt     <= '0;
            rst_out <= rst_out << 1;
            if (rst_out == LAST_STAGE) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (lock_lost) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          cnt     <= '0;
          rst_out <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // Saturating count of lock-loss events; holds at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_count <= 8'd0;
    end else if (lock_lost && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule
